// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator operand-entry logic.
package calc_pkg;

  typedef enum logic {
    EDIT = 1'b0,
    FLOW = 1'b1
  } mode_t;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/calc_lifo.sv
// Pending-operand LIFO; push/pop act on the sampling edge, top is read combinationally.
module calc_lifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign wr_idx = AW'(count);
  assign rd_idx = AW'(count - CW'(1));
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign dout   = empty ? '0 : mem[rd_idx];

  // Storage carries no reset; only count decides what is visible.
  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_idx] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/calc_operand_stack.sv
// Calculator key decoder and operand-entry FSM in front of the pending-operand LIFO.
//  state | meaning
//  EDIT  | digits append to entry
//  FLOW  | entry shows a result/pushed value; next digit starts a new operand
module calc_operand_stack
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         newhex,
  input  logic                         newop,
  input  logic                         eq,
  input  logic                         bs,
  input  logic                         clr,
  input  logic                         neg,
  input  logic [3:0]                   hexcode,
  input  logic [WIDTH-1:0]             answer,
  output logic [WIDTH-1:0]             entry,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         err
);

  localparam int NDIG_MAX = WIDTH / 4;
  localparam int NW       = $clog2(NDIG_MAX + 1);

  mode_t         mode;
  logic [NW-1:0] ndig;
  logic          push;
  logic          pop;

  // eq outranks newop, so a simultaneous newop must not push.
  assign push = newop && !eq;
  assign pop  = eq;

  calc_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (top),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entry <= '0;
      ndig  <= '0;
      mode  <= EDIT;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (eq) begin
        entry <= answer;
        mode  <= FLOW;
      end else if (newop) begin
        mode <= FLOW;
        err  <= full;
      end else if (clr) begin
        entry <= '0;
        ndig  <= '0;
        mode  <= EDIT;
      end else if (bs) begin
        entry <= {4'h0, entry[WIDTH-1:4]};
        if (ndig != '0) ndig <= ndig - NW'(1);
        mode  <= EDIT;
      end else if (neg) begin
        entry <= -entry;
      end else if (newhex) begin
        if (mode == FLOW) begin
          entry <= {{(WIDTH-4){1'b0}}, hexcode};
          ndig  <= (hexcode != 4'h0) ? NW'(1) : '0;
          mode  <= EDIT;
        end else if (ndig < NW'(NDIG_MAX)) begin
          entry <= {entry[WIDTH-5:0], hexcode};
          // Leading zeros are not significant digits.
          if (!(entry == '0 && hexcode == 4'h0)) ndig <= ndig + NW'(1);
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_operand_stack.sv
// Directed bench for calc_operand_stack at WIDTH=16, DEPTH=4.
module tb_calc_operand_stack;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        newhex = 0, newop = 0, eq = 0, bs = 0, clr = 0, neg = 0;
  logic [3:0]  hexcode = '0;
  logic [15:0] answer = '0;
  logic [15:0] entry, top;
  logic [2:0]  count;
  logic        full, empty, err;

  int checks = 0;
  int fails  = 0;

  localparam logic [5:0] K_EQ  = 6'b100000;
  localparam logic [5:0] K_OP  = 6'b010000;
  localparam logic [5:0] K_CLR = 6'b001000;
  localparam logic [5:0] K_BS  = 6'b000100;
  localparam logic [5:0] K_NEG = 6'b000010;
  localparam logic [5:0] K_HEX = 6'b000001;

  calc_operand_stack #(.WIDTH(16), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .newhex(newhex), .newop(newop), .eq(eq),
    .bs(bs), .clr(clr), .neg(neg), .hexcode(hexcode), .answer(answer),
    .entry(entry), .top(top), .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clock = ~clock;

  // Drive keys on the falling edge; return 1 time unit after the sampling edge.
  task automatic press(input logic [5:0] k, input logic [3:0] h, input logic [15:0] a);
    @(negedge clock);
    {eq, newop, clr, bs, neg, newhex} = k;
    hexcode = h;
    answer  = a;
    @(posedge clock);
    #1;
    {eq, newop, clr, bs, neg, newhex} = '0;
  endtask

  task automatic hex(input logic [3:0] h);
    press(K_HEX, h, 16'h0);
  endtask

  task automatic idle();
    press(6'b0, 4'h0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (entry !== 16'h0) begin fails++; $display("FAIL reset_entry: got %h want 0000", entry); end
    checks++; if (top !== 16'h0) begin fails++; $display("FAIL reset_top: got %h want 0000", top); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_digits();
    hex(4'h1); hex(4'h2); hex(4'h3); hex(4'h4);
    checks++; if (entry !== 16'h1234) begin fails++; $display("FAIL digits_entry: got %h want 1234", entry); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL digits_noerr: got %b want 0", err); end
    hex(4'h5);
    checks++; if (entry !== 16'h1234) begin fails++; $display("FAIL digits_overflow_entry: got %h want 1234", entry); end
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL digits_overflow_err: got %b want 1", err); end
    idle();
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL digits_err_pulse: got %b want 0", err); end
    idle();
    checks++; if (entry !== 16'h1234) begin fails++; $display("FAIL digits_hold: got %h want 1234", entry); end
  endtask

  task automatic test_leading_zeros();
    press(K_CLR, 4'h0, 16'h0);
    checks++; if (entry !== 16'h0) begin fails++; $display("FAIL clr_entry: got %h want 0000", entry); end
    press(K_BS, 4'h0, 16'h0);
    hex(4'h0); hex(4'h0); hex(4'h0); hex(4'h0); hex(4'h0);
    hex(4'hA); hex(4'hB); hex(4'hC);
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL lz_noerr: got %b want 0", err); end
    hex(4'hD);
    checks++; if (entry !== 16'hABCD) begin fails++; $display("FAIL lz_entry: got %h want abcd", entry); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL lz_fourth_noerr: got %b want 0", err); end
    hex(4'h0);
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL lz_full_err: got %b want 1", err); end
  endtask

  task automatic test_bs_neg();
    press(K_CLR, 4'h0, 16'h0);
    hex(4'h1); hex(4'h2); hex(4'h3);
    checks++; if (entry !== 16'h0123) begin fails++; $display("FAIL bs_setup: got %h want 0123", entry); end
    press(K_BS, 4'h0, 16'h0);
    press(K_BS, 4'h0, 16'h0);
    checks++; if (entry !== 16'h0001) begin fails++; $display("FAIL bs_entry: got %h want 0001", entry); end
    press(K_NEG, 4'h0, 16'h0);
    checks++; if (entry !== 16'hFFFF) begin fails++; $display("FAIL neg_entry: got %h want ffff", entry); end
    press(K_BS, 4'h0, 16'h0);
    checks++; if (entry !== 16'h0FFF) begin fails++; $display("FAIL bs_logical: got %h want 0fff", entry); end
    press(K_CLR, 4'h0, 16'h0);
    hex(4'h8); hex(4'h0); hex(4'h0); hex(4'h0);
    press(K_NEG, 4'h0, 16'h0);
    checks++; if (entry !== 16'h8000) begin fails++; $display("FAIL neg_minval: got %h want 8000", entry); end
  endtask

  task automatic test_push_flow();
    press(K_CLR, 4'h0, 16'h0);
    hex(4'h7);
    press(K_OP, 4'h0, 16'h0);
    checks++; if (count !== 3'd1) begin fails++; $display("FAIL push_count: got %0d want 1", count); end
    checks++; if (top !== 16'h0007) begin fails++; $display("FAIL push_top: got %h want 0007", top); end
    checks++; if (empty !== 1'b0) begin fails++; $display("FAIL push_empty: got %b want 0", empty); end
    hex(4'h2);
    checks++; if (entry !== 16'h0002) begin fails++; $display("FAIL flow_overwrite: got %h want 0002", entry); end
    hex(4'h3);
    checks++; if (entry !== 16'h0023) begin fails++; $display("FAIL flow_then_edit: got %h want 0023", entry); end
  endtask

  task automatic test_full();
    do_reset();
    hex(4'h1); press(K_OP, 4'h0, 16'h0);
    hex(4'h2); press(K_OP, 4'h0, 16'h0);
    hex(4'h3); press(K_OP, 4'h0, 16'h0);
    hex(4'h4); press(K_OP, 4'h0, 16'h0);
    checks++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d want 4", count); end
    checks++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b want 1", full); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL fill_noerr: got %b want 0", err); end
    press(K_OP, 4'h0, 16'h0);
    checks++; if (count !== 3'd4) begin fails++; $display("FAIL over_count: got %0d want 4", count); end
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL over_err: got %b want 1", err); end
    checks++; if (top !== 16'h0004) begin fails++; $display("FAIL over_top: got %h want 0004", top); end
    press(K_EQ, 4'h0, 16'h0055);
    checks++; if (count !== 3'd3) begin fails++; $display("FAIL pop_count: got %0d want 3", count); end
    checks++; if (top !== 16'h0003) begin fails++; $display("FAIL pop_top: got %h want 0003", top); end
    checks++; if (entry !== 16'h0055) begin fails++; $display("FAIL pop_entry: got %h want 0055", entry); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL pop_err: got %b want 0", err); end
  endtask

  task automatic test_eq_priority();
    do_reset();
    hex(4'h5);
    press(K_OP, 4'h0, 16'h0);
    press(K_EQ | K_HEX, 4'h3, 16'h0009);
    checks++; if (entry !== 16'h0009) begin fails++; $display("FAIL eqhex_entry: got %h want 0009", entry); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL eqhex_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL eqhex_empty: got %b want 1", empty); end
    hex(4'h6);
    checks++; if (entry !== 16'h0006) begin fails++; $display("FAIL eq_flow_mode: got %h want 0006", entry); end
    press(K_EQ, 4'h0, 16'hABCD);
    checks++; if (entry !== 16'hABCD) begin fails++; $display("FAIL eq_empty_entry: got %h want abcd", entry); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL eq_empty_err: got %b want 0", err); end
    press(K_OP | K_CLR, 4'h0, 16'h0);
    checks++; if (entry !== 16'hABCD) begin fails++; $display("FAIL op_over_clr_entry: got %h want abcd", entry); end
    checks++; if (top !== 16'hABCD) begin fails++; $display("FAIL op_over_clr_top: got %h want abcd", top); end
    press(K_BS | K_NEG, 4'h0, 16'h0);
    checks++; if (entry !== 16'h0ABC) begin fails++; $display("FAIL bs_over_neg: got %h want 0abc", entry); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hex(4'h1); press(K_OP, 4'h0, 16'h0);
    hex(4'h2); press(K_OP, 4'h0, 16'h0);
    hex(4'h3); press(K_OP, 4'h0, 16'h0);
    hex(4'h9);
    checks++; if (count !== 3'd3) begin fails++; $display("FAIL mid_setup_count: got %0d want 3", count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (entry !== 16'h0) begin fails++; $display("FAIL mid_entry: got %h want 0000", entry); end
    checks++; if (count !== 3'd0) begin fails++; $display("FAIL mid_count: got %0d want 0", count); end
    checks++; if (top !== 16'h0) begin fails++; $display("FAIL mid_top: got %h want 0000", top); end
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL mid_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL mid_full: got %b want 0", full); end
    @(negedge clock);
    reset = 1'b1;
    press(K_OP, 4'h0, 16'h0);
    checks++; if (count !== 3'd1) begin fails++; $display("FAIL post_reset_count: got %0d want 1", count); end
    checks++; if (top !== 16'h0) begin fails++; $display("FAIL post_reset_top: got %h want 0000", top); end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_leading_zeros();
    test_bs_neg();
    test_push_flow();
    test_full();
    test_eq_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/calc_operand_stack.md
CALC_OPERAND_STACK -- requirements
Module: calc_operand_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 from 8 to 32.
REQ-002 SHALL have parameter DEPTH, default 4, number of pending-operand stack entries; legal values are 2 to 8.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports newhex/newop/eq/bs/clr/neg  input  1 each  key strobes: hex digit, operator, equals, backspace, clear entry, sign toggle; each is one cycle wide.
REQ-006 SHALL have port hexcode  input  4  digit value; qualified by newhex.
REQ-007 SHALL have port answer  input  WIDTH  signed arithmetic result; sampled only when eq=1.
REQ-008 SHALL have port entry  output  WIDTH  signed operand being edited or displayed.
REQ-009 SHALL have port top  output  WIDTH  signed top-of-stack operand; 0 when the stack is empty.
REQ-010 SHALL have port count  output  clog2(DEPTH+1)  number of stacked operands.
REQ-011 SHALL have ports full/empty  output  1 each  count==DEPTH / count==0.
REQ-012 SHALL have port err  output  1  registered one-cycle pulse on a rejected key.

Function
REQ-013 SHALL keep a mode state machine with states EDIT (digits append) and FLOW (next digit starts a new operand).
REQ-014 SHALL keep a digit counter ndig, range 0..WIDTH/4, holding the number of significant digits in entry.
REQ-015 SHALL act on at most one strobe per cycle, by priority eq > newop > clr > bs > neg > newhex; lower-priority strobes in the same cycle are ignored without err.
REQ-016 On eq: entry<=answer, pop one stack entry if not empty (no err if empty), mode<=FLOW.
REQ-017 On newop: push entry if not full and mode<=FLOW; if full, stack is unchanged, err pulses, and mode<=FLOW.
REQ-018 On clr: entry<=0, ndig<=0, mode<=EDIT; stack is unchanged.
REQ-019 On bs: entry<={4'h0, entry[WIDTH-1:4]} (logical shift), ndig decrements with saturation at 0, mode<=EDIT.
REQ-020 On neg: entry<=two's-complement negation of entry, wrapping (most-negative value maps to itself); ndig and mode are unchanged.
REQ-021 On newhex in FLOW: entry<=zero-extended hexcode, ndig<=(hexcode!=0), mode<=EDIT.
REQ-022 On newhex in EDIT with ndig<WIDTH/4: entry<={entry[WIDTH-5:0],hexcode}; ndig increments unless entry==0 and hexcode==0.
REQ-023 On newhex in EDIT with ndig==WIDTH/4: the digit is discarded, err pulses, and nothing else changes.
REQ-024 Push and pop SHALL take effect on the edge the strobe is sampled; top, count, full and empty SHALL update in the same cycle as entry (no added latency).
REQ-025 With no strobe asserted, all state SHALL hold.

Reset
REQ-026 While reset=0: entry=0, ndig=0, mode=EDIT, count=0, top=0, empty=1, full=0, err=0; stack storage contents are don't-care.
REQ-027 Reset asserted mid-operation SHALL abandon any pending push or pop; the first strobe after deassertion SHALL behave as from power-up.

Structure
REQ-028 Shared package calc_pkg SHALL hold the mode enum (EDIT, FLOW) and default WIDTH/DEPTH constants.
REQ-029 The stack SHALL be a sub-module calc_lifo (parameters WIDTH, DEPTH; inputs push, pop, din; outputs dout, count, full, empty); the key decoder and the mode FSM remain in the top level.

Verification
REQ-030 After reset, apply newhex 1,2,3,4 -> entry=0x1234, ndig=4; a fifth digit 5 -> entry still 0x1234, err pulses for one cycle.
REQ-031 With entry=0x0123, apply bs twice -> entry=0x0001; then neg -> entry=0xFFFF.
REQ-032 With entry=0x0007, apply newop -> count=1, top=0x0007; then newhex 2 -> entry=0x0002 (FLOW overwrite).
REQ-033 Fill the stack with 4 newop strobes (DEPTH=4), then a 5th newop -> count stays 4, full=1, err pulses.
REQ-034 With count=1, apply eq and newhex together, answer=0x0009 -> entry=0x0009, count=0, mode=FLOW, digit ignored.
REQ-035 Assert reset for one cycle mid-sequence with count=3 -> all outputs equal their REQ-026 values immediately, without waiting for a clock edge.
